// File: rtl/mmd_divider.sv
// Programmable multi-modulus divider: divides Clk by a per-period modulus taken
// from the delta-sigma modulator and paces the modulator with a request strobe.
module mmd_divider #(
    parameter int N_W   = 5,
    parameter int N_MIN = 4
) (
    input  logic           Clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [N_W-1:0] N_in,
    output logic           N_req,
    output logic           div_out,
    output logic           div_pulse,
    output logic [N_W-1:0] N_cur,
    output logic           clamp_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [N_W-1:0] N_MIN_V = N_W'(N_MIN);
    localparam logic [N_W-1:0] ONE     = N_W'(1);
    localparam logic [N_W-1:0] ZERO    = '0;

    logic [0:0]     state, state_nxt;
    logic [N_W-1:0] count, count_nxt;
    logic [N_W-1:0] n_cur_nxt;
    logic [N_W-1:0] n_load;
    logic           n_clamped;
    logic           load;
    logic           run_nxt;

    always_comb begin
        n_clamped = (N_in < N_MIN_V);
        n_load    = n_clamped ? N_MIN_V : N_in;
    end

    // A new modulus is only ever taken at a period boundary (or leaving IDLE),
    // so a dropped enable always lets the current period run to completion.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        n_cur_nxt = N_cur;
        load      = 1'b0;
        case (state)
            IDLE: begin
                count_nxt = ZERO;
                if (enable) begin
                    load = 1'b1;
                end
            end
            RUN: begin
                if (count != ZERO) begin
                    count_nxt = count - ONE;
                end else if (enable) begin
                    load = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    count_nxt = ZERO;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = ZERO;
            end
        endcase
        if (load) begin
            state_nxt = RUN;
            n_cur_nxt = n_load;
            count_nxt = n_load - ONE;
        end
        run_nxt = (state_nxt == RUN);
    end

    // Strobes and the divided clock are decoded from next-state so they come
    // straight off flops and cannot glitch.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= ZERO;
            N_cur     <= N_MIN_V;
            N_req     <= 1'b0;
            div_out   <= 1'b0;
            div_pulse <= 1'b0;
            clamp_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            N_cur     <= n_cur_nxt;
            N_req     <= run_nxt && (count_nxt == ONE);
            div_pulse <= run_nxt && (count_nxt == ZERO);
            div_out   <= run_nxt && (count_nxt >= (n_cur_nxt >> 1));
            clamp_err <= clamp_err | (load & n_clamped);
        end
    end

endmodule

// File: tb/tb_mmd_divider.sv
// Scoreboard bench for mmd_divider: stimulus queues expected periods, a negedge
// monitor measures each divided period and checks it against the queue.
module tb_mmd_divider;

    localparam int N_W   = 5;
    localparam int N_MIN = 4;

    logic           Clk    = 1'b0;
    logic           reset  = 1'b0;
    logic           enable = 1'b0;
    logic [N_W-1:0] N_in   = 5'd16;
    logic           N_req;
    logic           div_out;
    logic           div_pulse;
    logic [N_W-1:0] N_cur;
    logic           clamp_err;

    typedef struct {
        int period;
        int high;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   restart_req  = 0;
    int   restart_seen = 0;
    int   seq[4] = '{20, 21, 19, 22};

    mmd_divider #(.N_W(N_W), .N_MIN(N_MIN)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .enable    (enable),
        .N_in      (N_in),
        .N_req     (N_req),
        .div_out   (div_out),
        .div_pulse (div_pulse),
        .N_cur     (N_cur),
        .clamp_err (clamp_err)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic pushPeriod(input int p);
        exp_t e;
        e.period = p;
        e.high   = (p + 1) / 2;
        sb.push_back(e);
    endtask

    // Called at a negedge; the following rising edge is the load edge.
    task automatic applyStimulus(input int n);
        N_in   = N_W'(n);
        enable = 1'b1;
        @(posedge Clk);
        restart_req++;
    endtask

    task automatic runPulses(input int n);
        int pulses = 0;
        int cyc    = 0;
        while (pulses < n && cyc < 2000) begin
            @(negedge Clk);
            cyc++;
            if (div_pulse) pulses++;
        end
        enable = 1'b0;
        checkOutput("pulse_count", pulses, n);
        @(posedge Clk);
        #1;
        checkOutput("sb_drain", sb.size(), 0);
    endtask

    task automatic checkIdle(input string tag);
        repeat (3) @(negedge Clk);
        checkOutput({tag, "_div_out"}, int'(div_out), 0);
        checkOutput({tag, "_div_pulse"}, int'(div_pulse), 0);
        checkOutput({tag, "_N_req"}, int'(N_req), 0);
    endtask

    // Monitor: measures each period (cycles, high cycles, request strobes).
    int  m_cyc = 0;
    int  m_high = 0;
    int  m_nreq = 0;
    bit  m_prev_nreq = 1'b0;
    always @(negedge Clk) begin
        if (!reset) begin
            m_cyc = 0; m_high = 0; m_nreq = 0; m_prev_nreq = 1'b0;
        end else begin
            if (restart_seen != restart_req) begin
                restart_seen = restart_req;
                m_cyc = 0; m_high = 0; m_nreq = 0; m_prev_nreq = 1'b0;
            end
            m_cyc++;
            if (div_out) m_high++;
            if (N_req) m_nreq++;
            if (div_pulse) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("period", m_cyc, e.period);
                    checkOutput("high_cycles", m_high, e.high);
                    checkOutput("N_cur", int'(N_cur), e.period);
                    checkOutput("nreq_per_period", m_nreq, 1);
                    checkOutput("nreq_before_pulse", int'(m_prev_nreq), 1);
                end
                m_cyc = 0; m_high = 0; m_nreq = 0;
            end
            m_prev_nreq = N_req;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses, cyc, t1, t5, idx;

        // Reset held with enable high
        enable = 1'b1;
        N_in   = 5'd16;
        repeat (3) @(negedge Clk);
        checkOutput("rst_div_out", int'(div_out), 0);
        checkOutput("rst_div_pulse", int'(div_pulse), 0);
        checkOutput("rst_N_req", int'(N_req), 0);
        checkOutput("rst_clamp_err", int'(clamp_err), 0);
        checkOutput("rst_N_cur", int'(N_cur), N_MIN);

        // Constant modulus 16
        reset = 1'b1;
        repeat (3) pushPeriod(16);
        applyStimulus(16);
        runPulses(3);
        checkOutput("n16_clamp_err", int'(clamp_err), 0);
        checkIdle("idle16");

        // Odd moduli
        repeat (2) pushPeriod(17);
        applyStimulus(17);
        runPulses(2);
        checkIdle("idle17");
        repeat (2) pushPeriod(31);
        applyStimulus(31);
        runPulses(2);
        checkIdle("idle31");

        // Sequence tracking with a DSM model advanced by N_req
        pushPeriod(20); pushPeriod(21); pushPeriod(19); pushPeriod(22); pushPeriod(20);
        idx = 0;
        applyStimulus(seq[0]);
        pulses = 0; cyc = 0; t1 = 0; t5 = 0;
        while (pulses < 5 && cyc < 1000) begin
            @(negedge Clk);
            cyc++;
            if (N_req) begin
                idx  = (idx + 1) % 4;
                N_in = N_W'(seq[idx]);
            end
            if (div_pulse) begin
                pulses++;
                if (pulses == 1) t1 = cyc;
                if (pulses == 5) t5 = cyc;
            end
        end
        enable = 1'b0;
        checkOutput("seq_pulses", pulses, 5);
        checkOutput("seq_span", t5 - t1, 82);
        @(posedge Clk);
        #1;
        checkOutput("seq_drain", sb.size(), 0);
        checkIdle("idle_seq");

        // Clamping: 0 then 3 both become 4, flag is sticky
        @(negedge Clk);
        reset = 1'b0;
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        repeat (2) pushPeriod(4);
        applyStimulus(0);
        @(negedge Clk);
        checkOutput("clamp_set", int'(clamp_err), 1);
        N_in = 5'd3;
        runPulses(2);
        checkOutput("clamp_sticky", int'(clamp_err), 1);
        checkIdle("idle_clamp");
        reset = 1'b0;
        @(negedge Clk);
        checkOutput("clamp_cleared", int'(clamp_err), 0);
        reset = 1'b1;
        pushPeriod(4);
        applyStimulus(4);
        runPulses(1);
        checkOutput("nmin_no_clamp", int'(clamp_err), 0);
        checkIdle("idle_nmin");

        // Graceful stop: enable dropped at count 10 of a 24-cycle period
        pushPeriod(24);
        applyStimulus(24);
        repeat (13) @(posedge Clk);
        @(negedge Clk);
        enable = 1'b0;
        runPulses(1);
        checkIdle("idle_stop");
        pushPeriod(18);
        applyStimulus(18);
        runPulses(1);
        checkIdle("idle18");

        // Asynchronous reset mid-period at count 5
        applyStimulus(16);
        repeat (10) @(posedge Clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_div_out", int'(div_out), 0);
        checkOutput("midrst_div_pulse", int'(div_pulse), 0);
        checkOutput("midrst_N_req", int'(N_req), 0);
        checkOutput("midrst_N_cur", int'(N_cur), N_MIN);
        @(negedge Clk);
        reset = 1'b1;
        pushPeriod(16);
        applyStimulus(16);
        runPulses(1);
        checkIdle("idle_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
